int_issue_queue: RTL

//  Integer reservation-station queue sitting directly upstream of the issue unit.
//  - Holds dispatched R-type/ALU-immediate ops and snoops the CDB to wake up source operands.
//  - Raises IssInt_Rdy when any entry is ready, and presents the oldest ready entry as the issue payload.
//  - Retires that entry in the cycle the issue unit grants Iss_Int.

---
 rtl/iss_pkg.sv | 76 +++++++
 rtl/iq_entry.sv | 39 +++
 rtl/int_issue_queue.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/iss_pkg.sv
// Shared issue-stage types: datapath widths, ALU opcodes, queue entry layout
// and the CDB wakeup rule shared by stored and dispatching entries.
package iss_pkg;

    localparam int TAG_W  = 6;
    localparam int ROB_W  = 5;
    localparam int DATA_W = 32;
    localparam int OPC_W  = 3;

    typedef enum logic [OPC_W-1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL
    } alu_op_e;

    typedef struct packed {
        logic              valid;
        alu_op_e           opcode;
        logic [TAG_W-1:0]  rs_tag;
        logic              rs_rdy;
        logic [DATA_W-1:0] rs_data;
        logic [TAG_W-1:0]  rt_tag;
        logic              rt_rdy;
        logic [DATA_W-1:0] rt_data;
        logic [TAG_W-1:0]  rd_tag;
        logic [ROB_W-1:0]  rob_tag;
    } iq_entry_t;

    typedef struct packed {
        alu_op_e           opcode;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [TAG_W-1:0]  rd_tag;
        logic [ROB_W-1:0]  rob_tag;
    } iss_payload_t;

    // A waiting operand whose tag matches the broadcast captures its data.
    function automatic iq_entry_t wake_entry(input iq_entry_t         e,
                                             input logic              cdb_valid,
                                             input logic [TAG_W-1:0]  cdb_tag,
                                             input logic [DATA_W-1:0] cdb_data);
        iq_entry_t w;
        w = e;
        if (e.valid && cdb_valid) begin
            if (!e.rs_rdy && e.rs_tag == cdb_tag) begin
                w.rs_rdy  = 1'b1;
                w.rs_data = cdb_data;
            end
            if (!e.rt_rdy && e.rt_tag == cdb_tag) begin
                w.rt_rdy  = 1'b1;
                w.rt_data = cdb_data;
            end
        end
        return w;
    endfunction

    function automatic logic entry_ready(input iq_entry_t e);
        return e.valid && e.rs_rdy && e.rt_rdy;
    endfunction

    function automatic iss_payload_t entry_payload(input iq_entry_t e);
        iss_payload_t p;
        p.opcode  = e.opcode;
        p.rs_data = e.rs_data;
        p.rt_data = e.rt_data;
        p.rd_tag  = e.rd_tag;
        p.rob_tag = e.rob_tag;
        return p;
    endfunction

endpackage

// File: rtl/iq_entry.sv
// One issue-queue slot: entry register plus its CDB tag compare.
// IQ_CDB_BYPASS_EN: readiness and payload seen by select include this cycle's CDB match.
module iq_entry
    import iss_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  iq_entry_t         d,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output iq_entry_t         q_woken,
    output logic              sel_rdy,
    output iss_payload_t      sel_payload
);

    iq_entry_t q;

    // NOTE: non-blocking assignments keep every slot sampling pre-edge neighbours during a shift.
    always_ff @(posedge clk) begin
        q <= d;
        // NOTE: only valid is cleared; payload fields are meaningless while valid is low.
        if (reset || clear) begin
            q.valid <= 1'b0;
        end
    end

    assign q_woken = wake_entry(q, cdb_valid, cdb_tag, cdb_data);

`ifdef IQ_CDB_BYPASS_EN
    assign sel_rdy     = entry_ready(q_woken);
    assign sel_payload = entry_payload(q_woken);
`else
    assign sel_rdy     = entry_ready(q);
    assign sel_payload = entry_payload(q);
`endif

endmodule

// File: rtl/int_issue_queue.sv
// Integer reservation-station queue: compacting shift queue, oldest-ready select, CDB wakeup.
// IQ_CDB_BYPASS_EN (optional macro): zero-cycle CDB wakeup-to-issue forwarding.
module int_issue_queue
    import iss_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              Dis_IntEn,
    input  logic [OPC_W-1:0]  Dis_Opcode,
    input  logic [TAG_W-1:0]  Dis_RsTag,
    input  logic              Dis_RsRdy,
    input  logic [DATA_W-1:0] Dis_RsData,
    input  logic [TAG_W-1:0]  Dis_RtTag,
    input  logic              Dis_RtRdy,
    input  logic [DATA_W-1:0] Dis_RtData,
    input  logic [TAG_W-1:0]  Dis_RdTag,
    input  logic [ROB_W-1:0]  Dis_RobTag,
    input  logic              Cdb_Valid,
    input  logic [TAG_W-1:0]  Cdb_Tag,
    input  logic [DATA_W-1:0] Cdb_Data,
    input  logic              Cdb_Flush,
    input  logic              Iss_Int,
    output logic              IntQ_Full,
    output logic              IssInt_Rdy,
    output logic [OPC_W-1:0]  IssInt_Opcode,
    output logic [DATA_W-1:0] IssInt_RsData,
    output logic [DATA_W-1:0] IssInt_RtData,
    output logic [TAG_W-1:0]  IssInt_RdTag,
    output logic [ROB_W-1:0]  IssInt_RobTag
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    iq_entry_t        woken    [DEPTH];
    iq_entry_t        shift_in [DEPTH];
    iq_entry_t        nxt      [DEPTH];
    iss_payload_t     slot_pl  [DEPTH];
    logic [DEPTH-1:0] slot_rdy;

    iq_entry_t    dis_entry;
    iq_entry_t    dis_woken;
    iss_payload_t sel_pl;
    logic         sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic         full_q;
    logic         iss_fire;
    logic         dis_fire;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        iq_entry u_entry (
            .clk         (clk),
            .reset       (reset),
            .clear       (Cdb_Flush),
            .d           (nxt[g]),
            .cdb_valid   (Cdb_Valid),
            .cdb_tag     (Cdb_Tag),
            .cdb_data    (Cdb_Data),
            .q_woken     (woken[g]),
            .sel_rdy     (slot_rdy[g]),
            .sel_payload (slot_pl[g])
        );
        if (g < DEPTH - 1) begin : g_up
            assign shift_in[g] = woken[g+1];
        end else begin : g_top
            assign shift_in[g] = '0;
        end
    end

    always_comb begin
        dis_entry         = '0;
        dis_entry.valid   = Dis_IntEn;
        dis_entry.opcode  = alu_op_e'(Dis_Opcode);
        dis_entry.rs_tag  = Dis_RsTag;
        dis_entry.rs_rdy  = Dis_RsRdy;
        dis_entry.rs_data = Dis_RsData;
        dis_entry.rt_tag  = Dis_RtTag;
        dis_entry.rt_rdy  = Dis_RtRdy;
        dis_entry.rt_data = Dis_RtData;
        dis_entry.rd_tag  = Dis_RdTag;
        dis_entry.rob_tag = Dis_RobTag;
    end

    // Dispatching operands see the same broadcast, so no wakeup slips past.
    assign dis_woken = wake_entry(dis_entry, Cdb_Valid, Cdb_Tag, Cdb_Data);

    // Descending scan: the lowest ready index is the last one written.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_pl    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (slot_rdy[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_pl    = slot_pl[i];
            end
        end
    end

    assign IssInt_Rdy    = sel_found;
    assign IssInt_Opcode = sel_pl.opcode;
    assign IssInt_RsData = sel_pl.rs_data;
    assign IssInt_RtData = sel_pl.rt_data;
    assign IssInt_RdTag  = sel_pl.rd_tag;
    assign IssInt_RobTag = sel_pl.rob_tag;
    assign IntQ_Full     = full_q;

    // A full queue still accepts a dispatch when an issue frees a slot this cycle.
    assign iss_fire = Iss_Int && sel_found;
    assign dis_fire = Dis_IntEn && (!full_q || iss_fire);
    assign wr_idx   = iss_fire ? IDX_W'(count - CNT_W'(1)) : IDX_W'(count);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            nxt[i] = woken[i];
            if (iss_fire && IDX_W'(i) >= sel_idx) begin
                nxt[i] = shift_in[i];
            end
            if (dis_fire && wr_idx == IDX_W'(i)) begin
                nxt[i] = dis_woken;
            end
        end
    end

    always_comb begin
        count_nxt = count;
        if (Cdb_Flush) begin
            count_nxt = '0;
        end else begin
            case ({dis_fire, iss_fire})
                2'b10:   count_nxt = count + CNT_W'(1);
                2'b01:   count_nxt = count - CNT_W'(1);
                default: count_nxt = count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            full_q <= 1'b0;
        end else begin
            count  <= count_nxt;
            full_q <= (count_nxt == CNT_W'(DEPTH));
        end
    end

    a_no_dispatch_when_full : assert property (
        @(posedge clk) disable iff (reset) !(Dis_IntEn && full_q && !iss_fire)
    );

endmodule
